// File: rtl/soc_system_clkgen_pkg.sv
// Shared constants for the soc_system programmable clock generator:
// register map, STATUS bit positions, divider floor and register-select type.
package soc_system_clkgen_pkg;

    localparam int ADDR_CTRL          = 0;
    localparam int ADDR_STATUS        = 1;
    localparam int ADDR_DIV_BASE      = 2;

    localparam int CTRL_ENABLE_BIT    = 0;
    localparam int STATUS_LOCKED_BIT  = 0;
    localparam int STATUS_PENDING_LSB = 8;

    localparam int MIN_DIV            = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_STATUS,
        SEL_DIV,
        SEL_PHASE
    } reg_sel_e;

    // PHASE registers sit directly above the DIV block, so their base depends on the channel count.
    function automatic int addr_phase_base(int num_clocks);
        return ADDR_DIV_BASE + num_clocks;
    endfunction

endpackage

// File: rtl/soc_system_clkgen_chan.sv
// One divided-clock channel: counter, shadow/active divider with boundary commit,
// registered outclk/tick. CLKGEN_PHASE_EN adds a start-phase load on enable rise.
module soc_system_clkgen_chan
    import soc_system_clkgen_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_q,
    input  logic             en_d,
    input  logic             div_we,
    input  logic [DIV_W-1:0] div_wdata,
`ifdef CLKGEN_PHASE_EN
    input  logic [DIV_W-1:0] phase,
`endif
    output logic             outclk,
    output logic             tick,
    output logic             pending,
    output logic [DIV_W-1:0] shadow
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             outclk_q, outclk_d;
    logic             tick_q, tick_d;
    logic [DIV_W:0]   half;
    logic             wrap;
    logic [DIV_W-1:0] start;

    assign half = ({1'b0, active_q} + 1'b1) >> 1;
    assign wrap = (cnt_q == active_q - 1'b1);

    // While disabled the active divide tracks the shadow, so the restart phase is bounded by it.
`ifdef CLKGEN_PHASE_EN
    assign start = (phase < shadow_q) ? phase : shadow_q - 1'b1;
`else
    assign start = '0;
`endif

    always_comb begin
        cnt_d     = cnt_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        outclk_d  = 1'b0;
        tick_d    = 1'b0;

        if (!en_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
            cnt_d     = en_d ? start : '0;
        end else if (!en_d) begin
            cnt_d = '0;
        end else begin
            outclk_d = ({1'b0, cnt_q} < half);
            tick_d   = wrap;
            if (wrap) begin
                cnt_d     = '0;
                active_d  = shadow_q;
                pending_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // A write on the wrap cycle lands after the commit above, so it waits for the next boundary.
        if (div_we) begin
            shadow_d = div_wdata;
            if (en_q) begin
                pending_d = 1'b1;
            end else begin
                active_d = div_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            active_q  <= DIV_W'(DEFAULT_DIV);
            shadow_q  <= DIV_W'(DEFAULT_DIV);
            pending_q <= 1'b0;
            outclk_q  <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            outclk_q  <= outclk_d;
            tick_q    <= tick_d;
        end
    end

    assign outclk  = outclk_q;
    assign tick    = tick_q;
    assign pending = pending_q;
    assign shadow  = shadow_q;

endmodule

// File: rtl/soc_system_clkgen.sv
// Runtime-programmable multi-output clock generator with Avalon-MM control and lock detect.
// Optional per-channel start phase registers are built when CLKGEN_PHASE_EN is defined.
module soc_system_clkgen
    import soc_system_clkgen_pkg::*;
#(
    parameter int NUM_CLOCKS  = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 48,
    parameter int LOCK_CYCLES = 16,
    parameter int ADDR_W      = 4
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     avs_address,
    input  logic                  avs_write,
    input  logic [31:0]           avs_writedata,
    input  logic                  avs_read,
    output logic [31:0]           avs_readdata,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] tick,
    output logic                  locked
);

    localparam int LOCK_W     = $clog2(LOCK_CYCLES + 1);
    localparam int PHASE_BASE = addr_phase_base(NUM_CLOCKS);

    logic                  enable_q, enable_d;
    logic [LOCK_W-1:0]     settle_q, settle_d;
    logic                  locked_q, locked_d;
    logic [31:0]           readdata_q, readdata_d;
    logic [31:0]           rd_mux;
    reg_sel_e              sel;
    int                    addr_i;
    int                    idx;
    logic [NUM_CLOCKS-1:0] div_we;
    logic [NUM_CLOCKS-1:0] pending;
    logic [DIV_W-1:0]      shadow [NUM_CLOCKS];
    logic [DIV_W-1:0]      wr_val;
    logic [DIV_W-1:0]      div_wdata;
    logic                  any_pending;
    logic                  unused_wdata;

    assign addr_i       = int'(avs_address);
    assign wr_val       = avs_writedata[DIV_W-1:0];
    assign div_wdata    = (wr_val < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : wr_val;
    assign unused_wdata = ^avs_writedata[31:DIV_W];
    assign any_pending  = |pending;

    always_comb begin
        sel = SEL_NONE;
        idx = 0;
        if (addr_i == ADDR_CTRL) begin
            sel = SEL_CTRL;
        end else if (addr_i == ADDR_STATUS) begin
            sel = SEL_STATUS;
        end else if (addr_i >= ADDR_DIV_BASE && addr_i < PHASE_BASE) begin
            sel = SEL_DIV;
            idx = addr_i - ADDR_DIV_BASE;
`ifdef CLKGEN_PHASE_EN
        end else if (addr_i >= PHASE_BASE && addr_i < PHASE_BASE + NUM_CLOCKS) begin
            sel = SEL_PHASE;
            idx = addr_i - PHASE_BASE;
`endif
        end
    end

    // Bus: a write takes effect on the edge that samples avs_write; a read returns on
    // avs_readdata one cycle later and always reflects state from before a same-cycle write.
    always_comb begin
        enable_d = enable_q;
        div_we   = '0;
        if (avs_write) begin
            if (sel == SEL_CTRL) begin
                enable_d = avs_writedata[CTRL_ENABLE_BIT];
            end
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                if (sel == SEL_DIV && i == idx) begin
                    div_we[i] = 1'b1;
                end
            end
        end
    end

`ifdef CLKGEN_PHASE_EN
    logic [DIV_W-1:0] phase_q [NUM_CLOCKS];
    logic [DIV_W-1:0] phase_d [NUM_CLOCKS];

    always_comb begin
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            phase_d[i] = phase_q[i];
            if (avs_write && sel == SEL_PHASE && i == idx) begin
                phase_d[i] = wr_val;
            end
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLOCKS; i++) phase_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CLOCKS; i++) phase_q[i] <= phase_d[i];
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (sel)
            SEL_CTRL: rd_mux[CTRL_ENABLE_BIT] = enable_q;
            SEL_STATUS: begin
                rd_mux[STATUS_LOCKED_BIT] = locked_q;
                rd_mux[STATUS_PENDING_LSB +: NUM_CLOCKS] = pending;
            end
            SEL_DIV: begin
                for (int i = 0; i < NUM_CLOCKS; i++) begin
                    if (i == idx) rd_mux[DIV_W-1:0] = shadow[i];
                end
            end
`ifdef CLKGEN_PHASE_EN
            SEL_PHASE: begin
                for (int i = 0; i < NUM_CLOCKS; i++) begin
                    if (i == idx) rd_mux[DIV_W-1:0] = phase_q[i];
                end
            end
`endif
            default: rd_mux = '0;
        endcase
        readdata_d = avs_read ? rd_mux : 32'd0;
    end

    // Lock drops on the edge of any disturbing write, ahead of the settle counter clearing.
    always_comb begin
        if (!enable_q || any_pending) begin
            settle_d = '0;
        end else if (settle_q == LOCK_W'(LOCK_CYCLES)) begin
            settle_d = settle_q;
        end else begin
            settle_d = settle_q + 1'b1;
        end
        locked_d = enable_q && enable_d && !any_pending && !(|div_we)
                   && (settle_q == LOCK_W'(LOCK_CYCLES));
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q   <= 1'b1;
            settle_q   <= '0;
            locked_q   <= 1'b0;
            readdata_q <= '0;
        end else begin
            enable_q   <= enable_d;
            settle_q   <= settle_d;
            locked_q   <= locked_d;
            readdata_q <= readdata_d;
        end
    end

    for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
        soc_system_clkgen_chan #(
            .DIV_W      (DIV_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_chan (
            .clk      (refclk),
            .rst_n    (rst_n),
            .en_q     (enable_q),
            .en_d     (enable_d),
            .div_we   (div_we[g]),
            .div_wdata(div_wdata),
`ifdef CLKGEN_PHASE_EN
            .phase    (phase_q[g]),
`endif
            .outclk   (outclk[g]),
            .tick     (tick[g]),
            .pending  (pending[g]),
            .shadow   (shadow[g])
        );
    end

    assign avs_readdata = readdata_q;
    assign locked       = locked_q;

endmodule
